// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared encodings for the multicycle main control FSM and ALU decode
package main_control_fsm_pkg;

  // Controller states; the numeric values are visible on the STATE debug port.
  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11
  } state_e;

  // ALU operation requests; SPECIAL hands funct3/funct7 decoding to ALU_DECODE.
  localparam logic [2:0] ALUOP_ADD     = 3'b000;
  localparam logic [2:0] ALUOP_SUB     = 3'b001;
  localparam logic [2:0] ALUOP_SPECIAL = 3'b111;

  // Memory address select.
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Supported major opcodes.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Everything the controller drives besides the debug state.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True for every opcode the controller knows how to sequence.
  function automatic logic opcode_known(input logic [6:0] opc);
    return (opc == OPC_LOAD)  || (opc == OPC_STORE)  || (opc == OPC_RTYPE) ||
           (opc == OPC_ITYPE) || (opc == OPC_BRANCH) || (opc == OPC_JAL);
  endfunction

  // State to enter after DECODE; unknown opcodes fall back to FETCH.
  function automatic state_e dispatch(input logic [6:0] opc);
    state_e nxt;
    case (opc)
      OPC_LOAD, OPC_STORE: nxt = S_MEMADR;
      OPC_RTYPE:           nxt = S_EXECR;
      OPC_ITYPE:           nxt = S_EXECI;
      OPC_BRANCH:          nxt = S_BRANCH;
      OPC_JAL:             nxt = S_JAL;
      default:             nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle RISC-V main controller, one instruction in flight
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       MEM_READY,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MEM_REQ,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUOP,
  output logic       ILLEGAL,
  output logic [3:0] STATE
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // Only funct3[0] matters here (BEQ vs BNE); the rest belongs to ALU_DECODE.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  // State register; reset lands in RST_S immediately, even mid-wait.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; strobes are gated by MEM_READY / Zero in the same cycle.
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURES;
        ctrl.ir_write   = MEM_READY;
        ctrl.pc_write   = MEM_READY;
        if (MEM_READY) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !opcode_known(opcode);
        state_d        = dispatch(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_ALUOUT;
        ctrl.result_src = RES_ALUOUT;
        if (MEM_READY) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = ADR_ALUOUT;
        if (MEM_READY) begin
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_SPECIAL;
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_SPECIAL;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        // funct3[0] inverts the sense: BEQ takes on Zero, BNE on !Zero.
        ctrl.pc_write   = Zero ^ funct3[0];
        state_d         = S_FETCH;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        state_d         = S_ALUWB;
      end
      default: begin
        // Unused encodings recover through the reset state.
        state_d = S_RST;
      end
    endcase
  end

  assign PCWrite   = ctrl.pc_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegWrite  = ctrl.reg_write;
  assign MemWrite  = ctrl.mem_write;
  assign MEM_REQ   = ctrl.mem_req;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOP     = ctrl.alu_op;
  assign ILLEGAL   = ctrl.illegal;
  assign STATE     = state_q;

endmodule
